perf_counter_bank: RTL and testbench

Parametrised bank of NUM_CNT event counters for CPU performance measurement, generalising the fixed cycle/instruction counters into one synthesizable block.
- Sits beside the CPU core in Microprocessor.
- Typical wiring: evt[0] tied high (cycle count), evt[1] = IF PC_EN (instruction count), remaining channels for stalls, flushes and coprocessor busy.
- Adds a run/halt state machine, masked clear, atomic snapshot, indexed readout and selectable wrap or saturate arithmetic.

---
 rtl/perf_counter_bank.sv | 124 ++++++++++++
 tb/tb_perf_counter_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with run/halt control, masked clear, atomic snapshot and indexed readout.
// Define PERF_OVF_IRQ_EN to build sticky per-channel overflow flags and the registered irq.
module perf_counter_bank #(
  parameter int NUM_CNT  = 4,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0,
  parameter int IDX_W    = (NUM_CNT > 1 ? $clog2(NUM_CNT) : 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic [NUM_CNT-1:0] evt,
  input  logic               clr,
  input  logic [NUM_CNT-1:0] clr_mask,
  input  logic               snap,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   rd_snap,
  output logic               running,
  output logic               frozen,
  output logic [NUM_CNT-1:0] ovf,
  output logic               irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q  [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d  [NUM_CNT];
  logic [CNT_W-1:0]   snap_q [NUM_CNT];
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wrap;
  logic [NUM_CNT-1:0] clr_sel;
  logic               count_en;

  // A start that arrives while halt is high is dropped in every state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start && !halt) state_d = ST_RUN;
      ST_RUN:    if (halt)           state_d = ST_FROZEN;
      ST_FROZEN: if (start && !halt) state_d = ST_RUN;
      default:                       state_d = ST_IDLE;
    endcase
  end

  assign count_en = (state_q == ST_RUN);
  assign running  = (state_q == ST_RUN);
  assign frozen   = (state_q == ST_FROZEN);
  assign clr_sel  = {NUM_CNT{clr}} & clr_mask;

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      inc[i]   = count_en && evt[i];
      wrap[i]  = inc[i] && (&cnt_q[i]);
      // Clear wins over an increment on the same channel; saturation holds all-ones.
      if (clr_sel[i]) begin
        cnt_d[i] = '0;
      end else if (inc[i] && !(wrap[i] && (SATURATE != 0))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      // NOTE: the counter and snapshot arrays are reset explicitly because software reads them as zero after reset.
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values; the snapshot sees pre-increment counts.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (snap) snap_q <= cnt_q;
    end
  end

  // Compare on the full index width so out-of-range indices never alias a channel.
  always_comb begin
    rd_cnt  = '0;
    rd_snap = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_cnt  = cnt_q[i];
        rd_snap = snap_q[i];
      end
    end
  end

`ifdef PERF_OVF_IRQ_EN
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic               irq_q;

  assign ovf_d = (ovf_q | wrap) & ~clr_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_q;
    end
  end

  assign ovf = ovf_q;
  assign irq = irq_q;
`else
  assign ovf = '0;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 32-bit wrap instance plus 4-bit wrap and saturate instances on shared stimulus.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       halt;
  logic [3:0] evt;
  logic       clr;
  logic [3:0] clr_mask;
  logic       snap;
  logic [2:0] rd_idx;

  logic [31:0] rd_cnt, rd_snap;
  logic        running, frozen, irq;
  logic [3:0]  ovf;
  logic [3:0]  rd_cnt_w, rd_snap_w, rd_cnt_s, rd_snap_s;
  logic        running_w, frozen_w, irq_w, running_s, frozen_s, irq_s;
  logic [3:0]  ovf_w, ovf_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CNT(4), .CNT_W(32), .SATURATE(0), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .evt(evt), .clr(clr),
    .clr_mask(clr_mask), .snap(snap), .rd_idx(rd_idx), .rd_cnt(rd_cnt),
    .rd_snap(rd_snap), .running(running), .frozen(frozen), .ovf(ovf), .irq(irq)
  );

  perf_counter_bank #(.NUM_CNT(4), .CNT_W(4), .SATURATE(0), .IDX_W(3)) dut_w (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .evt(evt), .clr(clr),
    .clr_mask(clr_mask), .snap(snap), .rd_idx(rd_idx), .rd_cnt(rd_cnt_w),
    .rd_snap(rd_snap_w), .running(running_w), .frozen(frozen_w), .ovf(ovf_w), .irq(irq_w)
  );

  perf_counter_bank #(.NUM_CNT(4), .CNT_W(4), .SATURATE(1), .IDX_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .evt(evt), .clr(clr),
    .clr_mask(clr_mask), .snap(snap), .rd_idx(rd_idx), .rd_cnt(rd_cnt_s),
    .rd_snap(rd_snap_s), .running(running_s), .frozen(frozen_s), .ovf(ovf_s), .irq(irq_s)
  );

  typedef struct {
    logic        start;
    logic        halt;
    logic [3:0]  evt;
    logic        clr;
    logic [3:0]  clr_mask;
    logic [2:0]  rd_idx;
    logic [31:0] exp_cnt;
    logic        exp_run;
    logic        exp_frz;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic st, logic hl, logic [3:0] ev, logic cl, logic [3:0] msk,
                              logic [2:0] idx, logic [31:0] cnt, logic run, logic frz);
    vec_t v;
    v.start = st; v.halt = hl; v.evt = ev; v.clr = cl; v.clr_mask = msk;
    v.rd_idx = idx; v.exp_cnt = cnt; v.exp_run = run; v.exp_frz = frz;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // Cycle-by-cycle run/halt/clear sequence for the 32-bit instance, starting from reset.
    tbl[0]  = mk(1, 1, 4'b0001, 0, 4'b0000, 0, 0, 0, 0);  // start under halt ignored
    tbl[1]  = mk(0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0);  // idle holds
    tbl[2]  = mk(1, 0, 4'b0001, 0, 4'b0000, 0, 0, 1, 0);  // accept cycle does not count
    tbl[3]  = mk(0, 0, 4'b0001, 0, 4'b0000, 0, 1, 1, 0);
    tbl[4]  = mk(1, 0, 4'b0001, 0, 4'b0000, 0, 2, 1, 0);  // start in RUN harmless
    tbl[5]  = mk(0, 0, 4'b0000, 0, 4'b0000, 0, 2, 1, 0);
    tbl[6]  = mk(0, 1, 4'b0001, 0, 4'b0000, 0, 3, 0, 1);  // halt cycle still counts
    tbl[7]  = mk(0, 1, 4'b0001, 0, 4'b0000, 0, 3, 0, 1);
    tbl[8]  = mk(0, 0, 4'b0001, 0, 4'b0000, 0, 3, 0, 1);
    tbl[9]  = mk(1, 0, 4'b0001, 0, 4'b0000, 0, 3, 1, 0);  // resume, no count this cycle
    tbl[10] = mk(0, 0, 4'b0001, 1, 4'b0001, 0, 0, 1, 0);  // clr beats increment
    tbl[11] = mk(0, 0, 4'b0001, 0, 4'b0000, 0, 1, 1, 0);
    tbl[12] = mk(0, 0, 4'b0001, 1, 4'b0010, 0, 2, 1, 0);  // unmasked channel keeps counting
    tbl[13] = mk(0, 0, 4'b0010, 0, 4'b0000, 1, 1, 1, 0);
    tbl[14] = mk(0, 1, 4'b0000, 0, 4'b0000, 0, 2, 0, 1);
    tbl[15] = mk(0, 1, 4'b0000, 1, 4'b1111, 0, 0, 0, 1);  // clear while frozen

    rst = 1'b1; start = 1'b0; halt = 1'b0; evt = '0; clr = 1'b0;
    clr_mask = '0; snap = 1'b0; rd_idx = '0;
    cyc();
    cyc();
    check("reset running", running, 0);
    check("reset frozen", frozen, 0);
    check("reset rd_cnt", rd_cnt, 0);
    check("reset rd_snap", rd_snap, 0);
    check("reset ovf", ovf, 0);
    check("reset irq", irq, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; halt = tbl[i].halt; evt = tbl[i].evt;
      clr = tbl[i].clr; clr_mask = tbl[i].clr_mask; rd_idx = tbl[i].rd_idx;
      cyc();
      check($sformatf("vec%0d rd_cnt", i), rd_cnt, tbl[i].exp_cnt);
      check($sformatf("vec%0d running", i), running, tbl[i].exp_run);
      check($sformatf("vec%0d frozen", i), frozen, tbl[i].exp_frz);
    end
    start = 1'b0; halt = 1'b0; evt = '0; clr = 1'b0; clr_mask = '0; rd_idx = '0;

    // 100 cycles on channels 0 and 1, then halt and confirm the counts freeze.
    do_reset();
    do_start();
    evt = 4'b0011;
    repeat (100) cyc();
    evt = 4'b0000;
    halt = 1'b1;
    cyc();
    check("halt frozen", frozen, 1);
    check("halt running", running, 0);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 3'(i);
      #1;
      check($sformatf("run100 ch%0d", i), rd_cnt, (i < 2) ? 100 : 0);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    evt = 4'b1111;
    repeat (20) cyc();
    check("frozen start ignored", frozen, 1);
    rd_idx = 3'd0;
    #1;
    check("frozen hold ch0", rd_cnt, 100);
    rd_idx = 3'd2;
    #1;
    check("frozen hold ch2", rd_cnt, 0);
    halt = 1'b0;
    evt = 4'b0000;

    // 4-bit wrap vs saturate on channel 2, with overflow flags when built.
    do_reset();
    do_start();
    rd_idx = 3'd2;
    evt = 4'b0100;
    repeat (16) cyc();
    check("wrap at 16", rd_cnt_w, 0);
    check("sat at 16", rd_cnt_s, 15);
`ifdef PERF_OVF_IRQ_EN
    check("ovf wrap set", ovf_w, 4'b0100);
    check("ovf sat set", ovf_s, 4'b0100);
    check("irq not yet", irq_w, 0);
`endif
    cyc();
    check("wrap 17 events", rd_cnt_w, 1);
`ifdef PERF_OVF_IRQ_EN
    check("irq next cycle", irq_w, 1);
`else
    check("ovf tied low", ovf_w, 0);
    check("irq tied low", irq_w, 0);
`endif
    repeat (3) cyc();
    check("wrap 20 events", rd_cnt_w, 4);
    check("sat 20 events", rd_cnt_s, 15);
    check("wide 20 events", rd_cnt, 20);
    evt = 4'b0000;
    clr = 1'b1;
    clr_mask = 4'b0100;
    cyc();
    clr = 1'b0;
    clr_mask = 4'b0000;
    check("clr wrap cnt", rd_cnt_w, 0);
    check("clr sat cnt", rd_cnt_s, 0);
    check("clr ovf", ovf_w, 0);
    cyc();
    check("clr irq", irq_w, 0);

    // Snapshot and clear in the same cycle: snapshot keeps the pre-clear value.
    do_reset();
    do_start();
    rd_idx = 3'd0;
    evt = 4'b0001;
    repeat (50) cyc();
    check("pre snap ch0", rd_cnt, 50);
    snap = 1'b1;
    clr = 1'b1;
    clr_mask = 4'b0001;
    cyc();
    snap = 1'b0;
    clr = 1'b0;
    clr_mask = 4'b0000;
    check("snap value", rd_snap, 50);
    check("snap clr cnt", rd_cnt, 0);
    cyc();
    check("resume after clr", rd_cnt, 1);
    check("snap held", rd_snap, 50);
    rd_idx = 3'd4;
    #1;
    check("idx4 rd_cnt", rd_cnt, 0);
    check("idx4 rd_snap", rd_snap, 0);
    rd_idx = 3'd5;
    #1;
    check("idx5 rd_cnt", rd_cnt, 0);
    check("idx5 rd_snap", rd_snap, 0);

    // Reset mid-RUN with every channel active.
    evt = 4'b1111;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst running", running, 0);
    check("rst frozen", frozen, 0);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 3'(i);
      #1;
      check($sformatf("rst ch%0d", i), rd_cnt, 0);
    end
    rd_idx = 3'd0;
    #1;
    check("rst snap", rd_snap, 0);
    cyc();
    check("idle after rst", rd_cnt, 0);
    evt = 4'b0000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
